// File: rtl/mode_ctl_seq.sv
// Mode sequencer for the clock front panel: debounces next/prev/home buttons on clk
// and steps through NUM_MODES modes, with an alarm lock and an optional idle timeout.
`timescale 1ns/1ps
module mode_ctl_seq #(
   parameter int NUM_MODES       = 4,
   parameter int MODE_W          = 2,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_next,
   input  logic              btn_prev,
   input  logic              btn_home,
   input  logic              alarm_ringing,
   output logic [MODE_W-1:0] mode,
   output logic              mode_changed,
   output logic              timed_out
);

   localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam bit                TO_EN     = (TIMEOUT_CYCLES > 0);
   localparam int                IDLE_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

   // Button lanes: bit 0 = next, bit 1 = prev, bit 2 = home.
   logic [2:0]        raw;
   logic [2:0]        sync_a;
   logic [2:0]        sync_b;
   logic [2:0]        level;
   logic [2:0]        level_d;
   logic [2:0]        press;
   logic [DB_W-1:0]   db_cnt [3];
   logic [IDLE_W-1:0] idle_cnt;

   logic              lock;
   logic              ev_next;
   logic              ev_prev;
   logic              ev_home;
   logic              any_ev;
   logic              expire;
   logic              illegal;
   logic [MODE_W-1:0] mode_nx;
   logic              to_nx;

   assign raw = {btn_home, btn_prev, btn_next};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a  <= '0;
         sync_b  <= '0;
         level   <= '0;
         level_d <= '0;
         press   <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_a  <= raw;
         sync_b  <= sync_a;
         level_d <= level;
         press   <= level & ~level_d;
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               level[i]  <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Next/prev are swallowed entirely in the display mode while the alarm rings.
   assign lock    = (mode == '0) && alarm_ringing;
   assign ev_next = press[0] & ~lock;
   assign ev_prev = press[1] & ~lock;
   assign ev_home = press[2];
   assign any_ev  = ev_next | ev_prev | ev_home;
   assign illegal = (32'(mode) >= 32'(NUM_MODES));
   assign expire  = TO_EN && (mode != '0) && (idle_cnt == IDLE_LAST);

   always_comb begin
      mode_nx = mode;
      to_nx   = 1'b0;
      if (ev_home) begin
         mode_nx = '0;
      end else if (ev_next && ev_prev) begin
         mode_nx = mode;
      end else if (ev_next) begin
         mode_nx = (illegal || mode == MODE_LAST) ? '0 : mode + 1'b1;
      end else if (ev_prev) begin
         if (illegal)           mode_nx = '0;
         else if (mode == '0)   mode_nx = MODE_LAST;
         else                   mode_nx = mode - 1'b1;
      end else if (expire) begin
         mode_nx = '0;
         to_nx   = 1'b1;
      end
   end

   // A simultaneous next+prev still counts as panel activity for the idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode         <= '0;
         mode_changed <= 1'b0;
         timed_out    <= 1'b0;
         idle_cnt     <= '0;
      end else begin
         mode         <= mode_nx;
         mode_changed <= (mode_nx != mode);
         timed_out    <= to_nx;
         if (!TO_EN || mode == '0 || any_ev || expire) idle_cnt <= '0;
         else                                          idle_cnt <= idle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mode_ctl_seq.sv
// Directed bench for mode_ctl_seq with NUM_MODES=5, MODE_W=3, DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=50: a vector table of button presses plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mode_ctl_seq;
   localparam int NM = 5;
   localparam int MW = 3;
   localparam int DB = 4;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_next = 1'b0;
   logic          btn_prev = 1'b0;
   logic          btn_home = 1'b0;
   logic          alarm_ringing = 1'b0;
   logic [MW-1:0] mode;
   logic          mode_changed;
   logic          timed_out;

   int n_checks = 0;
   int n_pass   = 0;
   int chg_cnt  = 0;
   int to_cnt   = 0;
   int cur_mode = 0;

   typedef struct {
      logic n;
      logic p;
      logic h;
      logic alarm;
      int   exp_mode;
   } vec_t;

   vec_t vecs [19];

   mode_ctl_seq #(
      .NUM_MODES(NM), .MODE_W(MW), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .btn_home(btn_home),
      .alarm_ringing(alarm_ringing), .mode(mode), .mode_changed(mode_changed),
      .timed_out(timed_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (mode_changed) chg_cnt += 1;
         if (timed_out)    to_cnt  += 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raw press applied just before an edge lands 8 edges later (4 + DEBOUNCE_CYCLES).
   task automatic press_chk(input logic n, input logic p, input logic h,
                            input int exp, input string name);
      btn_next = n;
      btn_prev = p;
      btn_home = h;
      tick(7);
      chk({name, "_early"}, int'(mode), cur_mode);
      tick(1);
      chk({name, "_mode"}, int'(mode), exp);
      chk({name, "_pulse"}, int'(mode_changed), int'(exp != cur_mode));
      btn_next = 1'b0;
      btn_prev = 1'b0;
      btn_home = 1'b0;
      cur_mode = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int c0;
      int exp_d;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 2};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 0};

      tick(2);
      chk("rst_mode", int'(mode), 0);
      chk("rst_changed", int'(mode_changed), 0);
      chk("rst_timed_out", int'(timed_out), 0);
      rst = 1'b0;
      tick(2);
      chk("post_rst_mode", int'(mode), 0);

      for (int i = 0; i < 19; i++) begin
         alarm_ringing = vecs[i].alarm;
         c0    = chg_cnt;
         exp_d = (vecs[i].exp_mode != cur_mode) ? 1 : 0;
         press_chk(vecs[i].n, vecs[i].p, vecs[i].h, vecs[i].exp_mode, $sformatf("vec%0d", i));
         tick(9);
         chk($sformatf("vec%0d_hold", i), int'(mode), vecs[i].exp_mode);
         chk($sformatf("vec%0d_npulses", i), chg_cnt - c0, exp_d);
      end
      alarm_ringing = 1'b0;
      chk("table_no_timeout", to_cnt, 0);

      // Bounce shorter than the debounce window
      c0 = chg_cnt;
      for (int i = 0; i < 5; i++) begin
         btn_next = 1'b1;
         tick(2);
         btn_next = 1'b0;
         tick(2);
      end
      tick(12);
      chk("bounce_mode", int'(mode), 0);
      chk("bounce_npulses", chg_cnt - c0, 0);

      // Idle timeout from mode 2
      press_chk(1'b1, 1'b0, 1'b0, 1, "to_a");
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 2, "to_b");
      c0 = to_cnt;
      tick(49);
      chk("to_before_mode", int'(mode), 2);
      chk("to_before_flag", int'(timed_out), 0);
      tick(1);
      chk("to_expire_mode", int'(mode), 0);
      chk("to_expire_changed", int'(mode_changed), 1);
      chk("to_expire_flag", int'(timed_out), 1);
      cur_mode = 0;
      tick(1);
      chk("to_flag_clear", int'(timed_out), 0);
      chk("to_npulses", to_cnt - c0, 1);

      // Press landing in the expiry cycle wins, then the timeout restarts
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 1, "to_c");
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 2, "to_d");
      tick(42);
      press_chk(1'b1, 1'b0, 1'b0, 3, "to_late");
      chk("to_late_flag", int'(timed_out), 0);
      tick(49);
      chk("to_restart_before", int'(mode), 3);
      tick(1);
      chk("to_restart_mode", int'(mode), 0);
      chk("to_restart_flag", int'(timed_out), 1);
      cur_mode = 0;

      // Asynchronous reset mid-debounce with the button held through release
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 1, "rs_a");
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 2, "rs_b");
      tick(8);
      press_chk(1'b1, 1'b0, 1'b0, 3, "rs_c");
      tick(8);
      btn_next = 1'b1;
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("rs_async_mode", int'(mode), 0);
      chk("rs_async_changed", int'(mode_changed), 0);
      tick(2);
      rst = 1'b0;
      cur_mode = 0;
      c0 = chg_cnt;
      tick(7);
      chk("rs_held_early", int'(mode), 0);
      tick(1);
      chk("rs_held_mode", int'(mode), 1);
      chk("rs_held_pulse", int'(mode_changed), 1);
      tick(20);
      chk("rs_held_final", int'(mode), 1);
      chk("rs_held_npulses", chg_cnt - c0, 1);
      btn_next = 1'b0;
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mode_ctl_seq.md
Name: mode_ctl_seq

Overview:
Parametrised successor to the clock's mode sequencer. It runs on the system clock instead of being clocked by a button, and debounces three front-panel buttons internally: next, prev and home. It steps through NUM_MODES modes with wrap-around in both directions and blocks mode entry while the alarm rings. An idle timeout returns the panel to the display mode. It feeds the display, set, timer and alarm-set datapaths and any added modes.

Parameters:
NUM_MODES, 4, number of modes; mode 0 is the display mode; legal range 2..2**MODE_W.
MODE_W, 2, width of the mode output.
DEBOUNCE_CYCLES, 20000, consecutive stable synchronised samples required to accept a button level change; must be >= 1.
TIMEOUT_CYCLES, 0, idle clk cycles in a non-zero mode before returning to mode 0; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
btn_next  input  1  raw, asynchronous, bouncing button: advance mode.
btn_prev  input  1  raw, asynchronous, bouncing button: step mode back.
btn_home  input  1  raw, asynchronous, bouncing button: return to mode 0.
alarm_ringing  input  1  alarm currently sounding; synchronous to clk.
mode  output  MODE_W  current mode, registered.
mode_changed  output  1  one-cycle pulse, registered; asserted in the cycle mode holds a new value.
timed_out  output  1  one-cycle pulse, registered; asserted together with mode_changed when the timeout caused the change.

Behaviour:
- Reset (asynchronous, active-high) clears the following to 0: mode, mode_changed, timed_out, all synchroniser flops, all debounced levels, the debounce counters and the idle counter.
- Per button, three stages:
  - 2-flop synchroniser.
  - Debouncer: while the synchronised value differs from the accepted level, the counter increments; any cycle where they match clears the counter. When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synchronised value and the counter clears.
  - Press event: registered one-cycle pulse on each 0->1 transition of the accepted level. Releases generate no event.
- Latency: a raw button held high from before clk edge 1 produces a mode update at edge 4+DEBOUNCE_CYCLES. Any bounce shorter than DEBOUNCE_CYCLES samples produces no event.
- Button held through reset release: the accepted level starts at 0, so one press is generated after the debounce interval.
- Next-mode decision, evaluated each cycle from the press events, in priority order:
  1. home press: mode <- 0. Always honoured, even while the alarm rings.
  2. next and prev pressed in the same cycle: both ignored; no change.
  3. next alone: mode <- mode+1, or 0 when mode = NUM_MODES-1.
  4. prev alone: mode <- mode-1, or NUM_MODES-1 when mode = 0.
  5. Idle timeout expiry: mode <- 0.
- Alarm lock: while mode = 0 and alarm_ringing = 1, next and prev presses are discarded, both for the mode and for the idle counter. In non-zero modes the alarm does not block stepping.
- mode_changed fires only when the mode value actually differs from its previous value. Example: home pressed while already in mode 0 gives no pulse.
- Idle counter:
  - Active only when TIMEOUT_CYCLES > 0 and mode != 0.
  - Clears on any honoured press and whenever mode = 0.
  - Otherwise increments each cycle. On reaching TIMEOUT_CYCLES-1, the next edge sets mode <- 0 and pulses timed_out.
  - A press arriving in the same cycle as expiry wins, and timed_out stays 0.
- Mode encoding is plain binary. Values >= NUM_MODES are never produced. If mode somehow holds an illegal value, next, prev, home and timeout all load 0.
- Widths: the idle counter is sized to hold TIMEOUT_CYCLES. Debounce counters are sized to hold DEBOUNCE_CYCLES. No counter may overflow.

Test Plan:
(Overrides for all scenarios: NUM_MODES=5, MODE_W=3, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.)
- Reset, then 6 clean next presses, each held 10 cycles -> mode 1,2,3,4,0,1. Each change lands at edge 8 after its press and carries a single mode_changed pulse.
- btn_next toggling every 2 cycles for 20 cycles, then low -> no press event; mode stays 0; mode_changed never asserts.
- mode=0 with alarm_ringing=1, then next and prev presses -> mode stays 0. Then a home press -> no change and no pulse. Then drop the alarm and press next -> mode 1.
- From mode 0, a prev press -> mode 4. Next and prev pressed in the same cycle -> stays 4. Home pressed together with next -> mode 0.
- Enter mode 2 and wait idle -> 50 cycles after the last event, mode 0 with mode_changed=1 and timed_out=1 in the same cycle. Repeat with a next press landing at cycle 49 -> mode 3, and the timeout restarts.
- Assert rst mid-debounce, with btn_next held and mode=3 -> mode 0 immediately, with no clock needed. After release with the button still held -> exactly one press -> mode 1.
